// File: rtl/clq_multi_if.sv
// Bundle of handshake, push, head-write and read-port signals of the
// successor clause queue. The slave modport is the queue. The master
// modport is its driver.
interface clq_multi_if #(
  parameter int DEPTH   = 16,
  parameter int NUM_LIT = 32,
  parameter int NODE_W  = 32,
  parameter int LIT_W   = 8,
  parameter int NUM_RD  = 2,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int HIDX_W  = $clog2(2*NUM_LIT)
);
  logic                       clear;
  logic                       load_done;
  logic                       push_valid;
  logic [NODE_W-1:0]          push_node;
  logic                       push_ready;
  logic                       head_wr_en;
  logic [HIDX_W-1:0]          head_wr_idx;
  logic [PTR_W-1:0]           head_wr_ptr;
  logic                       head_wr_vld;
  logic                       uc_valid;
  logic signed [LIT_W-1:0]    uc_lit;
  logic                       uc_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [PTR_W-1:0]           rsp_ptr;
  logic                       rsp_hit;
  logic                       rsp_err;
  logic [NUM_RD*PTR_W-1:0]    rd_idx;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*NODE_W-1:0]   rd_node;
  logic [NUM_RD-1:0]          rd_node_valid;
  logic [PTR_W:0]             count;
  logic                       mode_active;

  modport slave (
    input  clear, load_done, push_valid, push_node,
    input  head_wr_en, head_wr_idx, head_wr_ptr, head_wr_vld,
    input  uc_valid, uc_lit, rsp_ready, rd_idx, rd_en,
    output push_ready, uc_ready, rsp_valid, rsp_ptr, rsp_hit, rsp_err,
    output rd_node, rd_node_valid, count, mode_active
  );

  modport master (
    output clear, load_done, push_valid, push_node,
    output head_wr_en, head_wr_idx, head_wr_ptr, head_wr_vld,
    output uc_valid, uc_lit, rsp_ready, rd_idx, rd_en,
    input  push_ready, uc_ready, rsp_valid, rsp_ptr, rsp_hit, rsp_err,
    input  rd_node, rd_node_valid, count, mode_active
  );
endinterface

// File: rtl/clq_multi.sv
// Successor clause queue. It holds the CNF node buffer, which is filled during
// LOAD, and a per-literal head-pointer table. It serves unit-clause lookups
// with a single registered response stage. It also gives each BCP engine its
// own registered node-read port.
module clq_multi #(
  parameter int DEPTH   = 16,
  parameter int NUM_LIT = 32,
  parameter int NODE_W  = 32,
  parameter int LIT_W   = 8,
  parameter int NUM_RD  = 2,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int HIDX_W  = $clog2(2*NUM_LIT)
) (
  input logic         clk,
  input logic         rst_n,
  clq_multi_if.slave  bus
);
  typedef enum logic {ST_LOAD, ST_ACTIVE} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       tail;
  logic [PTR_W:0]         count_q;
  logic [NODE_W-1:0]      node_buf [DEPTH];
  logic [PTR_W-1:0]       head_ptr [2*NUM_LIT];
  logic [2*NUM_LIT-1:0]   head_vld;

  logic                   push_fire;
  logic                   uc_fire;
  logic signed [LIT_W:0]  lit_ext;
  logic [LIT_W:0]         lit_mag;
  logic                   lk_err;
  logic                   lk_hit;
  logic [HIDX_W-1:0]      lk_idx;

  assign bus.mode_active = (state == ST_ACTIVE);
  assign bus.count       = count_q;
  assign bus.push_ready  = (state == ST_LOAD) && (count_q != (PTR_W+1)'(DEPTH));
  assign bus.uc_ready    = bus.mode_active && (!bus.rsp_valid || bus.rsp_ready);
  assign push_fire       = bus.push_valid && bus.push_ready;
  assign uc_fire         = bus.uc_valid && bus.uc_ready;

  // Literal to head-table index. The magnitude is one bit wider than the
  // literal, so that the most negative literal does not overflow.
  always_comb begin
    lit_ext = {bus.uc_lit[LIT_W-1], bus.uc_lit};
    lit_mag = lit_ext[LIT_W] ? -lit_ext : lit_ext;
    lk_err  = (lit_mag == '0) || (32'(lit_mag) > NUM_LIT);
    lk_idx  = lit_ext[LIT_W] ? HIDX_W'(NUM_LIT + 32'(lit_mag) - 1)
                             : HIDX_W'(32'(lit_mag) - 1);
    lk_hit  = !lk_err && head_vld[lk_idx];
  end

  // Mode FSM and fill pointers. A clear returns the block to an empty LOAD.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // block samples pre-edge values regardless of evaluation order.
    if (!rst_n || bus.clear) begin
      state   <= ST_LOAD;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (state == ST_LOAD && bus.load_done) state <= ST_ACTIVE;
      if (push_fire) begin
        tail    <= tail + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Node buffer append. A clear leaves the stale contents in place.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is zeroed only on rst_n. Reads are masked by count, so
    // stale data after a clear can never be observed.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) node_buf[i] <= '0;
    end else if (push_fire && !bus.clear) begin
      node_buf[tail] <= bus.push_node;
    end
  end

  // Head table write. Only the valid bits need clearing; pointers are gated by them.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      head_vld <= '0;
    end else if (bus.head_wr_en && (32'(bus.head_wr_idx) < 2*NUM_LIT)) begin
      head_vld[bus.head_wr_idx] <= bus.head_wr_vld;
      head_ptr[bus.head_wr_idx] <= bus.head_wr_ptr;
    end
  end

  // Lookup response register. It loads on accept and holds until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_ptr   <= '0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else if (uc_fire) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_err   <= lk_err;
      bus.rsp_hit   <= lk_hit;
      bus.rsp_ptr   <= lk_hit ? head_ptr[lk_idx] : '0;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

  // Per-engine registered node reads. Indices at or past count return an invalid zero word.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      bus.rd_node_valid <= '0;
      bus.rd_node       <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.rd_en[i]) begin
          if ({1'b0, bus.rd_idx[i*PTR_W +: PTR_W]} < count_q) begin
            bus.rd_node_valid[i]          <= 1'b1;
            bus.rd_node[i*NODE_W +: NODE_W] <= node_buf[bus.rd_idx[i*PTR_W +: PTR_W]];
          end else begin
            bus.rd_node_valid[i]          <= 1'b0;
            bus.rd_node[i*NODE_W +: NODE_W] <= '0;
          end
        end else begin
          bus.rd_node_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_clq_multi.sv
// Directed bench for clq_multi. Inputs change 1 time unit after each posedge.
// Outputs are sampled in the same window.
module tb_clq_multi;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  clq_multi_if bus ();

  clq_multi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear = 0; bus.load_done = 0; bus.push_valid = 0; bus.push_node = '0;
    bus.head_wr_en = 0; bus.head_wr_idx = '0; bus.head_wr_ptr = '0; bus.head_wr_vld = 0;
    bus.uc_valid = 0; bus.uc_lit = '0; bus.rsp_ready = 1; bus.rd_idx = '0; bus.rd_en = '0;
  endtask

  // One accepted lookup with rsp_ready high. The response is checked one cycle later.
  task automatic lookup(input string tag, input logic signed [7:0] lit,
                        input logic hit, input logic [3:0] ptr, input logic err);
    bus.uc_valid = 1; bus.uc_lit = lit; bus.rsp_ready = 1;
    #1 check({tag, "_uc_ready"}, bus.uc_ready, 1);
    tick();
    bus.uc_valid = 0;
    check({tag, "_valid"}, bus.rsp_valid, 1);
    check({tag, "_hit"},   bus.rsp_hit,   hit);
    check({tag, "_ptr"},   bus.rsp_ptr,   ptr);
    check({tag, "_err"},   bus.rsp_err,   err);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    check("rst_count", bus.count, 0);
    check("rst_mode", bus.mode_active, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_ptr", bus.rsp_ptr, 0);
    check("rst_push_ready", bus.push_ready, 1);
    check("rst_uc_ready", bus.uc_ready, 0);
    check("rst_rd_valid", bus.rd_node_valid, 0);
    check("rst_rd_node", bus.rd_node, 0);

    // Three pushes. A head write (idx 4, ptr 2) goes with the first one.
    for (int k = 0; k < 3; k++) begin
      bus.push_valid = 1; bus.push_node = 32'hA0 + k;
      bus.head_wr_en = (k == 0); bus.head_wr_idx = 6'd4; bus.head_wr_ptr = 4'd2; bus.head_wr_vld = 1;
      tick();
    end
    bus.push_valid = 0; bus.head_wr_en = 0;
    check("load_count3", bus.count, 3);
    bus.load_done = 1;
    tick();
    bus.load_done = 0;
    check("act_mode", bus.mode_active, 1);
    check("act_push_ready", bus.push_ready, 0);
    lookup("lit_p5", 8'sd5, 1, 4'd2, 0);
    tick();
    check("drain_valid", bus.rsp_valid, 0);

    // Head write in ACTIVE (idx 36, ptr 7). Then back-to-back lookups.
    bus.head_wr_en = 1; bus.head_wr_idx = 6'd36; bus.head_wr_ptr = 4'd7; bus.head_wr_vld = 1;
    tick();
    bus.head_wr_en = 0;
    lookup("lit_m5", -8'sd5, 1, 4'd7, 0);
    lookup("lit_m6", -8'sd6, 0, 4'd0, 0);
    lookup("lit_0", 8'sd0, 0, 4'd0, 1);
    lookup("lit_p33", 8'sd33, 0, 4'd0, 1);
    lookup("lit_m128", -8'sd128, 0, 4'd0, 1);
    lookup("lit_m32", -8'sd32, 0, 4'd0, 0);

    // A head write in the same cycle as the lookup is not visible to that lookup.
    bus.head_wr_en = 1; bus.head_wr_idx = 6'd0; bus.head_wr_ptr = 4'd3; bus.head_wr_vld = 1;
    lookup("same_cyc_wr", 8'sd1, 0, 4'd0, 0);
    bus.head_wr_en = 0;
    lookup("after_wr", 8'sd1, 1, 4'd3, 0);
    tick();

    // Backpressure: hold the response for three cycles. Then one accept with no bubble.
    bus.uc_valid = 1; bus.uc_lit = 8'sd5; bus.rsp_ready = 0;
    tick();
    bus.uc_lit = -8'sd5;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_ptr", bus.rsp_ptr, 2);
      check("bp_uc_ready", bus.uc_ready, 0);
      tick();
    end
    bus.rsp_ready = 1;
    #1 check("bp_release_ready", bus.uc_ready, 1);
    tick();
    bus.uc_valid = 0;
    check("bp_second_valid", bus.rsp_valid, 1);
    check("bp_second_ptr", bus.rsp_ptr, 7);
    tick();
    check("bp_drained", bus.rsp_valid, 0);

    // Read ports: same index on both ports. Then an index equal to count.
    bus.rd_en = 2'b11; bus.rd_idx = {4'd1, 4'd1};
    tick();
    check("rd_same_valid", bus.rd_node_valid, 2'b11);
    check("rd_same_node", bus.rd_node, {32'hA1, 32'hA1});
    bus.rd_idx = {4'd3, 4'd2};
    tick();
    check("rd_oob_valid", bus.rd_node_valid, 2'b01);
    check("rd_oob_node", bus.rd_node, {32'h0, 32'hA2});
    bus.rd_en = 2'b00;
    tick();
    check("rd_idle_valid", bus.rd_node_valid, 2'b00);
    check("rd_idle_hold", bus.rd_node, {32'h0, 32'hA2});

    // Clear while a response is pending in ACTIVE.
    bus.uc_valid = 1; bus.uc_lit = 8'sd5; bus.rsp_ready = 0;
    tick();
    bus.uc_valid = 0;
    check("pre_clr_valid", bus.rsp_valid, 1);
    bus.clear = 1;
    tick();
    bus.clear = 0; bus.rsp_ready = 1;
    check("clr_valid", bus.rsp_valid, 0);
    check("clr_mode", bus.mode_active, 0);
    check("clr_count", bus.count, 0);
    check("clr_push_ready", bus.push_ready, 1);
    bus.load_done = 1;
    tick();
    bus.load_done = 0;
    lookup("clr_lit_p5", 8'sd5, 0, 4'd0, 0);
    lookup("clr_lit_m5", -8'sd5, 0, 4'd0, 0);
    tick();

    // Fill to DEPTH from an empty LOAD. An extra push is refused.
    bus.clear = 1;
    tick();
    bus.clear = 0;
    for (int k = 0; k < 16; k++) begin
      bus.push_valid = 1; bus.push_node = 32'h100 + k;
      tick();
    end
    check("full_count", bus.count, 16);
    check("full_push_ready", bus.push_ready, 0);
    bus.push_node = 32'hDEAD;
    tick();
    bus.push_valid = 0;
    check("full_count_hold", bus.count, 16);
    bus.rd_en = 2'b11; bus.rd_idx = {4'd0, 4'd15};
    tick();
    bus.rd_en = 2'b00;
    check("full_rd_valid", bus.rd_node_valid, 2'b11);
    check("full_rd_node", bus.rd_node, {32'h100, 32'h10F});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
